// File: rtl/div_unit_pkg.sv
// Shared state encoding and handshake constants for the
// multi-cycle divider.
package div_unit_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_READY     = 1'b1;
  localparam logic DIV_NOT_READY = 1'b0;
  localparam logic DIV_START     = 1'b1;
  localparam logic DIV_STOP      = 1'b0;

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division trial subtract on the shifted
// partial remainder; borrow means "keep the old remainder".
module div_sub_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   i_a,
  input  logic [DATA_W:0]   i_b,
  output logic [DATA_W-1:0] o_diff,
  output logic              o_borrow
);

  logic [DATA_W:0] w_full;

  // a < 2*b always holds, so the top difference bit is
  // set exactly when the subtraction would go negative.
  assign w_full   = i_a - i_b;
  assign o_diff   = w_full[DATA_W-1:0];
  assign o_borrow = w_full[DATA_W];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned restoring divider for DIV/DIVU.
// Returns {remainder, quotient} DATA_W cycles after acceptance.
import div_unit_pkg::*;

module div_unit #(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int CNT_W = $clog2(DATA_W);

  div_state_e r_state;
  div_state_e w_state_n;

  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_div;
  logic [2*DATA_W-1:0] w_step;
  logic [2*DATA_W-1:0] r_result;
  logic [DATA_W-1:0]   r_op2;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_ready;

  logic [DATA_W-1:0] w_abs1;
  logic [DATA_W-1:0] w_abs2;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_quo;
  logic [DATA_W-1:0] w_rem;
  logic              w_borrow;
  logic              w_last;
  logic              w_s1;
  logic              w_s2;

  assign w_s1 = signed_div_i & opdata1_i[DATA_W-1];
  assign w_s2 = signed_div_i & opdata2_i[DATA_W-1];

  assign w_abs1 = w_s1 ? -opdata1_i : opdata1_i;
  assign w_abs2 = w_s2 ? -opdata2_i : opdata2_i;

  assign w_last = (r_cnt == CNT_W'(DATA_W-1));

  div_sub_step #(
    .DATA_W (DATA_W)
  ) u_sub (
    .i_a      (r_div[2*DATA_W-1:DATA_W-1]),
    .i_b      ({1'b0, r_op2}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // Upper half is the partial remainder, lower half
  // shifts in quotient bits from the right.
  assign w_step = w_borrow
    ? {r_div[2*DATA_W-2:0], 1'b0}
    : {w_diff, r_div[DATA_W-2:0], 1'b1};

  assign w_quo = r_neg_q ? -w_step[DATA_W-1:0]
                         : w_step[DATA_W-1:0];
  assign w_rem = r_neg_r ? -w_step[2*DATA_W-1:DATA_W]
                         : w_step[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= DIV_FREE;
    else      r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) w_state_n = DIV_BYZERO;
          else                 w_state_n = DIV_ON;
        end
      end
      DIV_BYZERO: begin
        if (annul_i) w_state_n = DIV_FREE;
        else         w_state_n = DIV_END;
      end
      DIV_ON: begin
        if (annul_i)     w_state_n = DIV_FREE;
        else if (w_last) w_state_n = DIV_END;
      end
      DIV_END: begin
        if (annul_i || start_i == DIV_STOP)
          w_state_n = DIV_FREE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_div    <= '0;
      r_op2    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_ready  <= DIV_NOT_READY;
      r_result <= '0;
    end else begin
      if (w_state_n == DIV_FREE) begin
        r_ready  <= DIV_NOT_READY;
        r_result <= '0;
      end else if (r_state == DIV_ON &&
                   w_state_n == DIV_END) begin
        r_ready  <= DIV_READY;
        r_result <= {w_rem, w_quo};
      end else if (r_state == DIV_BYZERO &&
                   w_state_n == DIV_END) begin
        r_ready  <= DIV_READY;
        r_result <= '0;
      end

      if (r_state == DIV_FREE && w_state_n == DIV_ON) begin
        r_div   <= {{DATA_W{1'b0}}, w_abs1};
        r_op2   <= w_abs2;
        r_cnt   <= '0;
        r_neg_q <= w_s1 ^ w_s2;
        r_neg_r <= w_s1;
      end else if (r_state == DIV_ON &&
                   w_state_n != DIV_FREE) begin
        r_div <= w_step;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign ready_o  = r_ready;
  assign result_o = r_result;

endmodule
